// File: rtl/sticky_rr_arbiter.sv
// rtl/sticky_rr_arbiter.sv - Round-robin arbiter with sticky grants bounded by MAX_HOLD cycles.
// Optional ARB_LOCK_EN adds a lock input that extends the current grant past MAX_HOLD.
module sticky_rr_arbiter #(
  parameter int NR       = 4,
  parameter int MAX_HOLD = 4,
  localparam int IW      = $clog2(NR),
  localparam int HW      = $clog2(MAX_HOLD + 1)
) (
  input  logic          clk,
  input  logic          reset_n,
  input  logic [NR-1:0] req,
  input  logic          stall,
`ifdef ARB_LOCK_EN
  input  logic          lock,
`endif
  output logic [NR-1:0] vgnt,
  output logic [IW-1:0] egnt,
  output logic          eval,
  output logic          gnt_new
);

  localparam logic [HW-1:0] HOLD_LAST = HW'(MAX_HOLD - 1);
  localparam logic [IW-1:0] LAST_IDX  = IW'(NR - 1);
  localparam logic [NR-1:0] ONE_HOT0  = NR'(1);

  logic [IW-1:0] cur_q, cur_n;
  logic          eval_q, eval_n;
  logic [HW-1:0] hold_q, hold_n;
  logic [IW-1:0] rr_q, rr_n;
  logic [NR-1:0] vgnt_q, vgnt_n;
  logic          new_q, new_n;

  logic          holder_req;
  logic          under_limit;
  logic          keep;
  logic          found;
  logic [IW-1:0] pick;

  // First set request at or after rr_q, wrapping modulo NR (not modulo 2^IW).
  always_comb begin
    found = 1'b0;
    pick  = '0;
    for (int i = 0; i < NR; i++) begin
      int idx;
      idx = int'(rr_q) + i;
      if (idx >= NR) idx = idx - NR;
      if (!found && req[idx[IW-1:0]]) begin
        found = 1'b1;
        pick  = idx[IW-1:0];
      end
    end
  end

  assign holder_req  = req[cur_q];
  assign under_limit = (hold_q < HOLD_LAST);

`ifdef ARB_LOCK_EN
  assign keep = eval_q && holder_req && (under_limit || lock);
`else
  assign keep = eval_q && holder_req && under_limit;
`endif

  always_comb begin
    cur_n  = cur_q;
    eval_n = eval_q;
    hold_n = hold_q;
    rr_n   = rr_q;
    vgnt_n = vgnt_q;
    new_n  = 1'b0;
    if (keep) begin
      // Saturation only matters when lock holds the grant past the limit.
      hold_n = under_limit ? hold_q + HW'(1) : hold_q;
    end else if (found) begin
      cur_n  = pick;
      eval_n = 1'b1;
      vgnt_n = ONE_HOT0 << pick;
      hold_n = '0;
      new_n  = 1'b1;
      rr_n   = (pick == LAST_IDX) ? '0 : pick + IW'(1);
    end else begin
      eval_n = 1'b0;
      vgnt_n = '0;
      hold_n = '0;
    end
  end

  always_ff @(posedge clk or negedge reset_n) begin
    if (!reset_n) begin
      cur_q  <= '0;
      eval_q <= 1'b0;
      hold_q <= '0;
      rr_q   <= '0;
      vgnt_q <= '0;
      new_q  <= 1'b0;
    end else if (!stall) begin
      cur_q  <= cur_n;
      eval_q <= eval_n;
      hold_q <= hold_n;
      rr_q   <= rr_n;
      vgnt_q <= vgnt_n;
      new_q  <= new_n;
    end
  end

  assign vgnt    = vgnt_q;
  assign egnt    = cur_q;
  assign eval    = eval_q;
  assign gnt_new = new_q;

endmodule

// File: tb/tb_sticky_rr_arbiter.sv
// tb/tb_sticky_rr_arbiter.sv - Self-checking bench for sticky_rr_arbiter (NR=4/MAX_HOLD=3 and NR=5/MAX_HOLD=1).
module tb_sticky_rr_arbiter;

  logic clk = 1'b0;
  always #5 clk = ~clk;

  logic       reset_n;
  logic [3:0] req;
  logic       stall;
  logic [3:0] vgnt;
  logic [1:0] egnt;
  logic       eval;
  logic       gnt_new;

  logic [4:0] req5;
  logic [4:0] vgnt5;
  logic [2:0] egnt5;
  logic       eval5;
  logic       gnt_new5;

`ifdef ARB_LOCK_EN
  logic       lock_in;
`endif

  sticky_rr_arbiter #(.NR(4), .MAX_HOLD(3)) dut (
    .clk(clk), .reset_n(reset_n), .req(req), .stall(stall),
`ifdef ARB_LOCK_EN
    .lock(lock_in),
`endif
    .vgnt(vgnt), .egnt(egnt), .eval(eval), .gnt_new(gnt_new)
  );

  sticky_rr_arbiter #(.NR(5), .MAX_HOLD(1)) dut5 (
    .clk(clk), .reset_n(reset_n), .req(req5), .stall(1'b0),
`ifdef ARB_LOCK_EN
    .lock(1'b0),
`endif
    .vgnt(vgnt5), .egnt(egnt5), .eval(eval5), .gnt_new(gnt_new5)
  );

  typedef struct {
    logic [3:0] req;
    logic       stall;
    logic       lock;
    logic [1:0] egnt;
    logic       eval;
    logic       gnt_new;
  } vec_t;

  vec_t tbl[$];
  vec_t exp_q[$];
  vec_t mon_e;
  int   mon_n = 0;
  int   checks = 0;
  int   errors = 0;

  task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s: got %0h expected %0h", name, act, exp);
    end
  endtask

  function automatic vec_t mk(input logic [3:0] r, input logic s, input logic l,
                              input logic [1:0] e, input logic v, input logic n);
    vec_t t;
    t.req = r; t.stall = s; t.lock = l; t.egnt = e; t.eval = v; t.gnt_new = n;
    return t;
  endfunction

  // Scoreboard: expectations are queued by the driver and retired one per clock.
  always @(posedge clk) begin
    #1;
    if (exp_q.size() > 0) begin
      mon_e = exp_q.pop_front();
      chk($sformatf("v%0d.egnt", mon_n), 32'(egnt), 32'(mon_e.egnt));
      chk($sformatf("v%0d.eval", mon_n), 32'(eval), 32'(mon_e.eval));
      chk($sformatf("v%0d.gnt_new", mon_n), 32'(gnt_new), 32'(mon_e.gnt_new));
      chk($sformatf("v%0d.vgnt", mon_n), 32'(vgnt),
          mon_e.eval ? (32'd1 << mon_e.egnt) : 32'd0);
      mon_n++;
    end
  end

  task automatic run_tbl();
    foreach (tbl[i]) begin
      req   = tbl[i].req;
      stall = tbl[i].stall;
`ifdef ARB_LOCK_EN
      lock_in = tbl[i].lock;
`endif
      exp_q.push_back(tbl[i]);
      @(negedge clk);
    end
    tbl.delete();
  endtask

  task automatic chk_zero(input string tag);
    chk({tag, ".vgnt"}, 32'(vgnt), 32'd0);
    chk({tag, ".egnt"}, 32'(egnt), 32'd0);
    chk({tag, ".eval"}, 32'(eval), 32'd0);
    chk({tag, ".gnt_new"}, 32'(gnt_new), 32'd0);
  endtask

  initial begin
    #100000;
    $display("FAIL timeout: simulation did not finish");
    $fatal(1, "timeout");
  end

  initial begin
    reset_n = 1'b0;
    req     = 4'hf;
    stall   = 1'b0;
    req5    = 5'h00;
`ifdef ARB_LOCK_EN
    lock_in = 1'b0;
`endif
    repeat (3) @(posedge clk);
    #1;
    chk_zero("rst");
    @(negedge clk);
    reset_n = 1'b1;

    // Rotation with MAX_HOLD=3: three cycles per holder.
    for (int i = 0; i < 13; i++)
      tbl.push_back(mk(4'hf, 1'b0, 1'b0, 2'((i / 3) % 4), 1'b1, (i % 3) == 0));
    // Holder drop: immediate re-pick, then idle.
    tbl.push_back(mk(4'h1, 1'b0, 1'b0, 2'd0, 1'b1, 1'b0));
    tbl.push_back(mk(4'h4, 1'b0, 1'b0, 2'd2, 1'b1, 1'b1));
    tbl.push_back(mk(4'h0, 1'b0, 1'b0, 2'd2, 1'b0, 1'b0));
    // Lone requester gets re-issued after each expiry.
    for (int i = 0; i < 7; i++)
      tbl.push_back(mk(4'h2, 1'b0, 1'b0, 2'd1, 1'b1, (i % 3) == 0));
    // Stall with hold_cnt=1 on index 2.
    tbl.push_back(mk(4'h4, 1'b0, 1'b0, 2'd2, 1'b1, 1'b1));
    tbl.push_back(mk(4'h4, 1'b0, 1'b0, 2'd2, 1'b1, 1'b0));
    tbl.push_back(mk(4'hf, 1'b1, 1'b0, 2'd2, 1'b1, 1'b0));
    tbl.push_back(mk(4'h0, 1'b1, 1'b0, 2'd2, 1'b1, 1'b0));
    tbl.push_back(mk(4'h9, 1'b1, 1'b0, 2'd2, 1'b1, 1'b0));
    tbl.push_back(mk(4'h2, 1'b1, 1'b0, 2'd2, 1'b1, 1'b0));
    tbl.push_back(mk(4'hf, 1'b1, 1'b0, 2'd2, 1'b1, 1'b0));
    tbl.push_back(mk(4'hc, 1'b0, 1'b0, 2'd2, 1'b1, 1'b0));
    tbl.push_back(mk(4'hc, 1'b0, 1'b0, 2'd3, 1'b1, 1'b1));
    // Stall freezes a pending gnt_new=1.
    tbl.push_back(mk(4'h0, 1'b1, 1'b0, 2'd3, 1'b1, 1'b1));
    tbl.push_back(mk(4'h0, 1'b1, 1'b0, 2'd3, 1'b1, 1'b1));
    tbl.push_back(mk(4'h0, 1'b0, 1'b0, 2'd3, 1'b0, 1'b0));
    // Grant in progress before a mid-cycle reset (rr_ptr ends at 1).
    tbl.push_back(mk(4'hf, 1'b0, 1'b0, 2'd0, 1'b1, 1'b1));
    tbl.push_back(mk(4'hf, 1'b0, 1'b0, 2'd0, 1'b1, 1'b0));
    run_tbl();

    #2;
    reset_n = 1'b0;
    #1;
    chk_zero("async_rst");
    @(negedge clk);
    reset_n = 1'b1;
    // Search must restart at index 0, so 0 wins over 3.
    tbl.push_back(mk(4'h9, 1'b0, 1'b0, 2'd0, 1'b1, 1'b1));
    run_tbl();

    // NR=5, pure round-robin: pointer wraps 4 -> 0.
    req = 4'h0;
    for (int i = 0; i < 6; i++) begin
      req5 = 5'h1f;
      @(posedge clk);
      #1;
      chk($sformatf("nr5.%0d.egnt", i), 32'(egnt5), 32'(i % 5));
      chk($sformatf("nr5.%0d.eval", i), 32'(eval5), 32'd1);
      chk($sformatf("nr5.%0d.gnt_new", i), 32'(gnt_new5), 32'd1);
      chk($sformatf("nr5.%0d.vgnt", i), 32'(vgnt5), 32'd1 << (i % 5));
      @(negedge clk);
    end
    req5 = 5'h00;

`ifdef ARB_LOCK_EN
    reset_n = 1'b0;
    @(negedge clk);
    reset_n = 1'b1;
    for (int i = 0; i < 10; i++)
      tbl.push_back(mk(4'hf, 1'b0, 1'b1, 2'd0, 1'b1, i == 0));
    tbl.push_back(mk(4'hf, 1'b0, 1'b0, 2'd1, 1'b1, 1'b1));
    run_tbl();
`endif

    @(negedge clk);
    if (exp_q.size() != 0) begin
      errors++;
      $display("FAIL drain: got %0d pending expected 0", exp_q.size());
    end
    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

endmodule

// File: doc/sticky_rr_arbiter.md
Name: sticky_rr_arbiter

Overview:
- Parametrised round-robin arbiter with sticky grants: a granted requester keeps the grant while it continues requesting, for at most MAX_HOLD consecutive cycles; the grant then rotates. This bounds starvation.
- Grant outputs are registered and can be frozen by stall.
- Sits in front of shared event-queue and memory ports wherever NR cores contend for one resource.

Parameters:
- NR, 4, number of requesters; legal range 2..64, non-power-of-2 allowed.
- MAX_HOLD, 4, maximum consecutive cycles one grant may be held; 1 gives pure round-robin; must be >= 1.

Ports:
- clk  input  1  clock; all state updates on rising edge.
- reset_n  input  1  asynchronous active-low reset.
- req  input  NR  per-requester request level.
- stall  input  1  freeze: when 1, all state and outputs hold and req is ignored.
- vgnt  output  NR  one-hot grant; all zeros when eval=0.
- egnt  output  $clog2(NR)  encoded granted index.
- eval  output  1  grant valid.
- gnt_new  output  1  one-cycle flag: this grant is newly issued (new index, or re-issue after hold expiry).

Behaviour:
- Reset (async assert, sync release):
  - vgnt=0, egnt=0, eval=0, gnt_new=0.
  - Internal hold_cnt=0, rr_ptr=0.
- Latency: req sampled at edge t produces outputs valid after edge t. One-cycle registered path; no combinational req-to-grant path.
- State: cur (= egnt register), eval, hold_cnt (width $clog2(MAX_HOLD+1)), rr_ptr (index where the search starts).
- Each edge with stall=0:
  - Keep: if eval=1 and req[cur]=1 and hold_cnt < MAX_HOLD-1, then grant unchanged, hold_cnt+1, gnt_new=0.
  - Pick: otherwise, search req for the first set bit starting at rr_ptr and ascending, wrapping modulo NR.
    - If found at k: egnt=k, eval=1, vgnt=1<<k, hold_cnt=0, gnt_new=1, rr_ptr=(k+1) mod NR.
    - The expiring holder sits at rr_ptr-1, so it is reached last. A lone requester is re-granted, with gnt_new=1.
  - None found: eval=0, vgnt=0, gnt_new=0; egnt, rr_ptr hold; hold_cnt=0.
- Wrap-around: rr_ptr increments mod NR, not mod 2^width. For NR=5, after index 4 the pointer returns to 0. egnt never >= NR.
- Holder dropping: if req[cur]=0, a Pick happens the same edge. No idle cycle is inserted if others are requesting.
- Stall: with stall=1 every register holds, including gnt_new (a held 1 stays 1). Hold count resumes from its frozen value on release.
- Reset mid-grant: immediately clears all outputs. After release, arbitration restarts at index 0.

Optional Feature:
- Macro ARB_LOCK_EN.
  - Defined: adds input lock (1 bit).
    - While eval=1 and req[cur]=1 and lock=1, Keep applies regardless of hold_cnt.
    - hold_cnt saturates at MAX_HOLD-1.
    - When lock drops, the normal expiry check resumes on the next edge, so a saturated count forces a Pick.
  - Undefined: no lock port; behaviour exactly as above.

Test Plan:
1. Reset: NR=4, MAX_HOLD=3, req=4'b1111 during reset -> all outputs 0. First edge after release -> egnt=0, vgnt=4'b0001, eval=1, gnt_new=1.
2. Rotation: req=4'b1111 held 13 cycles -> egnt sequence 0,0,0,1,1,1,2,2,2,3,3,3,0. gnt_new=1 on cycles 1,4,7,10,13 only.
3. Holder drop: grant on 0, then req changes 4'b0001 -> 4'b0100 -> next edge egnt=2, gnt_new=1, no eval=0 gap. Then req=0 -> eval=0, vgnt=0, egnt stays 2.
4. Lone requester: req=4'b0010 for 7 cycles -> egnt=1 and eval=1 throughout; gnt_new pulses on cycles 1,4,7.
5. Stall: grant on 2 with hold_cnt=1; stall=1 for 5 cycles while req changes -> outputs frozen. Release with req[2]=1 -> exactly 1 more cycle on 2, then move to 3 if requesting. Also NR=5 with all requesting -> egnt cycles 0..4,0 with no value 5..7.
6. ARB_LOCK_EN: req=4'b1111, lock=1 for 10 cycles -> egnt=0 for all 10. lock=0 -> next edge egnt=1, gnt_new=1.
